// File: rtl/sram_req_remap.sv
// sram_req_remap: remaps core-side OBI requests into resident SRAM block slots.
//
// Requests whose address falls inside the virtual window [WinBase, WinBase+WinSize) are
// translated: the block address (relative to WinBase) is presented to the request-blocker
// controller, which returns the resident slot index or holds block_i while it swaps the block
// in. The request is then forwarded with a physical address inside the SRAM slot region.
// Requests outside the window are forwarded unchanged. Responses pass straight through, and
// the number of forwarded-but-unanswered transactions is limited to MaxTrans.
//
// Optional build macro: SRAM_REQ_REMAP_STATS_EN adds saturating stall/miss counters.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   sbr_req_i / sbr_gnt_o          upstream A-channel handshake
//   sbr_addr_i, sbr_we_i, sbr_be_i, sbr_wdata_i, sbr_aid_i   upstream A-channel fields
//   sbr_rvalid_o, sbr_rdata_o, sbr_rid_o, sbr_err_o          upstream R-channel
//   mgr_req_o / mgr_gnt_i          downstream A-channel handshake
//   mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o, mgr_aid_o   downstream A-channel fields
//   mgr_rvalid_i, mgr_rdata_i, mgr_rid_i, mgr_err_i          downstream R-channel
//   req_addr_o, valid_o            block lookup towards the blocker controller
//   sram_addr_idx_i, block_i       lookup result from the blocker controller
//   stall_cnt_o, miss_cnt_o        statistics (SRAM_REQ_REMAP_STATS_EN only)

module sram_req_remap #(
    parameter int unsigned NumSramAddr = 4,
    parameter int unsigned OffsetWidth = 11,
    parameter logic [31:0] WinBase     = 32'h2000_0000,
    parameter logic [31:0] WinSize     = 32'h1000_0000,
    parameter logic [31:0] SramBase    = 32'h1000_0000,
    parameter int unsigned IdWidth     = 1,
    parameter int unsigned MaxTrans    = 2,
    localparam int unsigned IdxWidth   = (NumSramAddr > 1) ? $clog2(NumSramAddr) : 1,
    localparam int unsigned BlockAddrWidth = 32 - OffsetWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // Upstream (core side)
    input  logic                      sbr_req_i,
    output logic                      sbr_gnt_o,
    input  logic [31:0]               sbr_addr_i,
    input  logic                      sbr_we_i,
    input  logic [3:0]                sbr_be_i,
    input  logic [31:0]               sbr_wdata_i,
    input  logic [IdWidth-1:0]        sbr_aid_i,
    output logic                      sbr_rvalid_o,
    output logic [31:0]               sbr_rdata_o,
    output logic [IdWidth-1:0]        sbr_rid_o,
    output logic                      sbr_err_o,
    // Downstream (SRAM side)
    output logic                      mgr_req_o,
    input  logic                      mgr_gnt_i,
    output logic [31:0]               mgr_addr_o,
    output logic                      mgr_we_o,
    output logic [3:0]                mgr_be_o,
    output logic [31:0]               mgr_wdata_o,
    output logic [IdWidth-1:0]        mgr_aid_o,
    input  logic                      mgr_rvalid_i,
    input  logic [31:0]               mgr_rdata_i,
    input  logic [IdWidth-1:0]        mgr_rid_i,
    input  logic                      mgr_err_i,
    // Blocker controller
    output logic [BlockAddrWidth-1:0] req_addr_o,
    output logic                      valid_o,
    input  logic [IdxWidth-1:0]       sram_addr_idx_i,
`ifdef SRAM_REQ_REMAP_STATS_EN
    output logic [31:0]               stall_cnt_o,
    output logic [15:0]               miss_cnt_o,
`endif
    input  logic                      block_i
);

    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    typedef enum logic [1:0] {StIdle, StLookup, StStall, StIssue} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             addr_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic [IdWidth-1:0]      aid_q;
    logic                    bypass_q;
    logic [IdxWidth-1:0]     idx_q;
    logic [CntWidth-1:0]     outstanding_q, outstanding_d;

    logic                    in_window;
    logic                    accept;
    logic                    capture;
    logic                    latch_idx;
    logic                    cnt_inc;
    logic [31:0]             phys_addr;

    // Unsigned wrap makes addresses below WinBase land far above WinSize.
    assign in_window = (sbr_addr_i - WinBase) < WinSize;
    assign accept    = sbr_req_i && (outstanding_q < CntWidth'(MaxTrans));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        latch_idx = 1'b0;
        valid_o   = 1'b0;
        mgr_req_o = 1'b0;
        sbr_gnt_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    capture = 1'b1;
                    state_d = in_window ? StLookup : StIssue;
                end
            end
            StLookup, StStall: begin
                valid_o = 1'b1;
                if (block_i) begin
                    state_d = StStall;
                end else begin
                    latch_idx = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                mgr_req_o = 1'b1;
                if (mgr_gnt_i) begin
                    sbr_gnt_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- Request capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            aid_q    <= '0;
            bypass_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            if (capture) begin
                addr_q   <= sbr_addr_i;
                we_q     <= sbr_we_i;
                be_q     <= sbr_be_i;
                wdata_q  <= sbr_wdata_i;
                aid_q    <= sbr_aid_i;
                bypass_q <= !in_window;
            end
            if (latch_idx) begin
                idx_q <= sram_addr_idx_i;
            end
        end
    end

    // ---------------------------------------------------------------- Outstanding counter
    assign cnt_inc = sbr_gnt_o;

    always_comb begin
        outstanding_d = outstanding_q;
        if (cnt_inc && !mgr_rvalid_i) begin
            outstanding_d = outstanding_q + CntWidth'(1);
        end else if (!cnt_inc && mgr_rvalid_i && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

`ifndef SYNTHESIS
    rvalid_without_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mgr_rvalid_i && !cnt_inc && (outstanding_q == '0)));
`endif

    // ---------------------------------------------------------------- Outputs
    // Block address relative to the window base; wraps modulo 2^BlockAddrWidth.
    assign req_addr_o = valid_o ? (addr_q[31:OffsetWidth] - WinBase[31:OffsetWidth]) : '0;

    assign phys_addr = SramBase + (32'(idx_q) << OffsetWidth)
                     + {{BlockAddrWidth{1'b0}}, addr_q[OffsetWidth-1:0]};

    assign mgr_addr_o  = !mgr_req_o ? '0 : (bypass_q ? addr_q : phys_addr);
    assign mgr_we_o    = mgr_req_o & we_q;
    assign mgr_be_o    = mgr_req_o ? be_q : '0;
    assign mgr_wdata_o = mgr_req_o ? wdata_q : '0;
    assign mgr_aid_o   = mgr_req_o ? aid_q : '0;

    assign sbr_rvalid_o = mgr_rvalid_i;
    assign sbr_rdata_o  = mgr_rdata_i;
    assign sbr_rid_o    = mgr_rid_i;
    assign sbr_err_o    = mgr_err_i;

`ifdef SRAM_REQ_REMAP_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if ((state_q == StStall) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((state_q == StLookup) && block_i && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sram_req_remap.sv
module tb_sram_req_remap;

    localparam logic [31:0] WinBase  = 32'h2000_0000;
    localparam logic [31:0] WinSize  = 32'h1000_0000;
    localparam logic [31:0] SramBase = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sbr_req_i, sbr_gnt_o, sbr_we_i;
    logic [31:0] sbr_addr_i, sbr_wdata_i;
    logic [3:0]  sbr_be_i;
    logic [0:0]  sbr_aid_i, sbr_rid_o, mgr_aid_o, mgr_rid_i;
    logic        sbr_rvalid_o, sbr_err_o;
    logic [31:0] sbr_rdata_o;
    logic        mgr_req_o, mgr_gnt_i, mgr_we_o;
    logic [31:0] mgr_addr_o, mgr_wdata_o, mgr_rdata_i;
    logic [3:0]  mgr_be_o;
    logic        mgr_rvalid_i, mgr_err_i;
    logic [20:0] req_addr_o;
    logic        valid_o, block_i;
    logic [1:0]  sram_addr_idx_i;
`ifdef SRAM_REQ_REMAP_STATS_EN
    logic [31:0] stall_cnt_o;
    logic [15:0] miss_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    sram_req_remap dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sbr_req_i       (sbr_req_i),
        .sbr_gnt_o       (sbr_gnt_o),
        .sbr_addr_i      (sbr_addr_i),
        .sbr_we_i        (sbr_we_i),
        .sbr_be_i        (sbr_be_i),
        .sbr_wdata_i     (sbr_wdata_i),
        .sbr_aid_i       (sbr_aid_i),
        .sbr_rvalid_o    (sbr_rvalid_o),
        .sbr_rdata_o     (sbr_rdata_o),
        .sbr_rid_o       (sbr_rid_o),
        .sbr_err_o       (sbr_err_o),
        .mgr_req_o       (mgr_req_o),
        .mgr_gnt_i       (mgr_gnt_i),
        .mgr_addr_o      (mgr_addr_o),
        .mgr_we_o        (mgr_we_o),
        .mgr_be_o        (mgr_be_o),
        .mgr_wdata_o     (mgr_wdata_o),
        .mgr_aid_o       (mgr_aid_o),
        .mgr_rvalid_i    (mgr_rvalid_i),
        .mgr_rdata_i     (mgr_rdata_i),
        .mgr_rid_i       (mgr_rid_i),
        .mgr_err_i       (mgr_err_i),
        .req_addr_o      (req_addr_o),
        .valid_o         (valid_o),
        .sram_addr_idx_i (sram_addr_idx_i),
`ifdef SRAM_REQ_REMAP_STATS_EN
        .stall_cnt_o     (stall_cnt_o),
        .miss_cnt_o      (miss_cnt_o),
`endif
        .block_i         (block_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          b;        // cycles the controller holds block_i while valid_o is high
        int          g;        // cycles mgr_gnt_i is withheld while mgr_req_o is high
        logic [1:0]  idx;
        logic [20:0] exp_req;
        logic [31:0] exp_phys;
        int          exp_nv;   // cycles with valid_o high
        int          exp_lat;  // cycles from request to sbr_gnt_o
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expectations straight from the address-window arithmetic.
    task automatic model(input logic [31:0] addr, input int b, input int g, input logic [1:0] idx,
                         output logic [20:0] exp_req, output logic [31:0] exp_phys,
                         output int exp_nv, output int exp_lat);
        logic [31:0] rel;
        bit          in_win;
        rel      = addr - WinBase;
        in_win   = rel < WinSize;
        exp_req  = 21'((addr >> 11) - (WinBase >> 11));
        exp_phys = in_win ? (SramBase + 32'(idx) * 32'd2048 + (addr % 32'd2048)) : addr;
        exp_nv   = in_win ? b + 1 : 0;
        exp_lat  = in_win ? b + 2 + g : 1 + g;
    endtask

    // Runs one request from IDLE; the bench plays both the blocker controller and the SRAM.
    task automatic run_txn(input string name, input logic [31:0] addr, input int b, input int g,
                           input logic [1:0] idx, input logic [20:0] exp_req,
                           input logic [31:0] exp_phys, input int exp_nv, input int exp_lat,
                           input bit do_rsp, input bit rsp_at_gnt);
        int          cyc = 0, nv = 0, ni = 0, badreq = 0, lat = -1;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
`ifdef SRAM_REQ_REMAP_STATS_EN
        logic [31:0] stall0 = stall_cnt_o;
        logic [15:0] miss0  = miss_cnt_o;
`endif
        we = 1'($urandom); be = 4'($urandom); wdata = $urandom; aid = 1'($urandom);
        sbr_req_i = 1'b1; sbr_addr_i = addr; sbr_we_i = we; sbr_be_i = be;
        sbr_wdata_i = wdata; sbr_aid_i = aid;
        while (lat < 0 && cyc < 200) begin
            block_i         = valid_o && (nv < b);
            sram_addr_idx_i = block_i ? ~idx : idx;
            mgr_gnt_i       = mgr_req_o && (ni >= g);
            mgr_rvalid_i    = mgr_gnt_i && rsp_at_gnt;
            mgr_rdata_i     = $urandom;
            @(negedge clk_i);
            if (valid_o) begin
                nv++;
                if (req_addr_o !== exp_req) badreq++;
            end
            if (sbr_gnt_o) begin
                lat = cyc;
                chk({name, " mgr_addr"}, mgr_addr_o, exp_phys);
                chk({name, " mgr_we"}, 32'(mgr_we_o), 32'(we));
                chk({name, " mgr_be"}, 32'(mgr_be_o), 32'(be));
                chk({name, " mgr_wdata"}, mgr_wdata_o, wdata);
                chk({name, " mgr_aid"}, 32'(mgr_aid_o), 32'(aid));
            end
            if (mgr_req_o) ni++;
            @(posedge clk_i); #1;
            cyc++;
        end
        sbr_req_i = 1'b0; block_i = 1'b0; mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " valid cycles"}, 32'(nv), 32'(exp_nv));
        chk({name, " req_addr mismatches"}, 32'(badreq), 32'd0);
`ifdef SRAM_REQ_REMAP_STATS_EN
        chk({name, " stall_cnt delta"}, stall_cnt_o - stall0, (exp_nv > 1) ? 32'(exp_nv - 1) : 0);
        chk({name, " miss_cnt delta"}, 32'(miss_cnt_o - miss0), (exp_nv > 1) ? 32'd1 : 32'd0);
`endif
        if (do_rsp) send_rsp(name);
    endtask

    task automatic send_rsp(input string name);
        logic [31:0] rdata = $urandom;
        logic [0:0]  rid   = 1'($urandom);
        logic        err   = 1'($urandom);
        mgr_rvalid_i = 1'b1; mgr_rdata_i = rdata; mgr_rid_i = rid; mgr_err_i = err;
        @(negedge clk_i);
        chk({name, " rvalid"}, 32'(sbr_rvalid_o), 32'd1);
        chk({name, " rdata"}, sbr_rdata_o, rdata);
        chk({name, " rid"}, 32'(sbr_rid_o), 32'(rid));
        chk({name, " err"}, 32'(sbr_err_o), 32'(err));
        @(posedge clk_i); #1;
        mgr_rvalid_i = 1'b0; mgr_err_i = 1'b0;
    endtask

    // Holds whatever request is pending and requires that nothing is issued or granted.
    task automatic check_blocked(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            mgr_gnt_i = mgr_req_o;
            @(negedge clk_i);
            if (valid_o || mgr_req_o || sbr_gnt_o) seen++;
            @(posedge clk_i); #1;
        end
        mgr_gnt_i = 1'b0;
        chk({name, " activity while full"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [20:0] e_req;
        logic [31:0] e_phys;
        int          e_nv, e_lat, b, g;
        logic [1:0]  idx;

        vecs[0] = '{32'h2000_0804, 0, 0, 2'd2, 21'h000001, 32'h1000_1004, 1, 2};
        vecs[1] = '{32'h2000_1000, 10, 0, 2'd3, 21'h000002, 32'h1000_1800, 11, 12};
        vecs[2] = '{32'h0300_0010, 0, 0, 2'd0, 21'h000000, 32'h0300_0010, 0, 1};
        vecs[3] = '{32'h2000_0000, 0, 2, 2'd0, 21'h000000, 32'h1000_0000, 1, 4};
        vecs[4] = '{32'h2FFF_FFFF, 1, 1, 2'd1, 21'h01FFFF, 32'h1000_0FFF, 2, 4};
        vecs[5] = '{32'h3000_0000, 0, 1, 2'd2, 21'h000000, 32'h3000_0000, 0, 2};
        vecs[6] = '{32'h1FFF_FFFF, 3, 0, 2'd1, 21'h000000, 32'h1FFF_FFFF, 0, 1};

        rst_ni = 1'b0; sbr_req_i = 0; sbr_addr_i = 0; sbr_we_i = 0; sbr_be_i = 0;
        sbr_wdata_i = 0; sbr_aid_i = 0; mgr_gnt_i = 0; mgr_rvalid_i = 0; mgr_rdata_i = 0;
        mgr_rid_i = 0; mgr_err_i = 0; block_i = 0; sram_addr_idx_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset sbr_gnt", 32'(sbr_gnt_o), 32'd0);
        chk("reset mgr_req", 32'(mgr_req_o), 32'd0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset mgr_addr", mgr_addr_o, 32'd0);
        chk("reset req_addr", 32'(req_addr_o), 32'd0);
`ifdef SRAM_REQ_REMAP_STATS_EN
        chk("reset stall_cnt", stall_cnt_o, 32'd0);
        chk("reset miss_cnt", 32'(miss_cnt_o), 32'd0);
`endif
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].b, vecs[i].g, vecs[i].idx,
                    vecs[i].exp_req, vecs[i].exp_phys, vecs[i].exp_nv, vecs[i].exp_lat, 1, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            addr = $urandom_range(0, 1) ? (WinBase + ($urandom % WinSize)) : $urandom;
            b    = int'($urandom_range(0, 4));
            g    = int'($urandom_range(0, 3));
            idx  = 2'($urandom);
            model(addr, b, g, idx, e_req, e_phys, e_nv, e_lat);
            run_txn($sformatf("rand%0d", i), addr, b, g, idx, e_req, e_phys, e_nv, e_lat, 1, 0);
        end

        // Outstanding limit: two unanswered grants, the third waits for a response
        model(32'h2000_0804, 0, 0, 2'd2, e_req, e_phys, e_nv, e_lat);
        run_txn("limA", 32'h2000_0804, 0, 0, 2'd2, e_req, e_phys, e_nv, e_lat, 0, 0);
        run_txn("limB", 32'h2000_0804, 0, 0, 2'd2, e_req, e_phys, e_nv, e_lat, 0, 0);
        sbr_req_i = 1'b1; sbr_addr_i = 32'h2000_0804;
        check_blocked("limC", 5);
        send_rsp("limC first rsp");
        run_txn("limC", 32'h2000_0804, 0, 0, 2'd2, e_req, e_phys, e_nv, e_lat, 1, 0);
        send_rsp("limC drain");

        // Grant and rvalid together with one outstanding: count stays at 1
        run_txn("simA", 32'h0300_0010, 0, 0, 2'd0, 21'h0, 32'h0300_0010, 0, 1, 0, 0);
        run_txn("simB", 32'h0300_0020, 0, 1, 2'd0, 21'h0, 32'h0300_0020, 0, 2, 0, 1);
        run_txn("simC", 32'h0300_0030, 0, 0, 2'd0, 21'h0, 32'h0300_0030, 0, 1, 0, 0);
        sbr_req_i = 1'b1; sbr_addr_i = 32'h0300_0040;
        check_blocked("simD", 4);
        sbr_req_i = 1'b0;
        send_rsp("sim drain1");
        send_rsp("sim drain2");

        // Reset in the middle of a stall, with one transaction outstanding
        run_txn("rstA", 32'h0300_0010, 0, 0, 2'd0, 21'h0, 32'h0300_0010, 0, 1, 0, 0);
        sbr_req_i = 1'b1; sbr_addr_i = 32'h2000_1000;
        for (int i = 0; i < 4; i++) begin
            block_i = valid_o;
            @(negedge clk_i);
            @(posedge clk_i); #1;
        end
        block_i = 1'b1;
        chk("stall before reset valid", 32'(valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("reset mid-stall valid", 32'(valid_o), 32'd0);
        chk("reset mid-stall mgr_req", 32'(mgr_req_o), 32'd0);
        chk("reset mid-stall sbr_gnt", 32'(sbr_gnt_o), 32'd0);
        sbr_req_i = 1'b0; block_i = 1'b0;
`ifdef SRAM_REQ_REMAP_STATS_EN
        chk("reset mid-stall stall_cnt", stall_cnt_o, 32'd0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        model(32'h2000_1000, 2, 0, 2'd3, e_req, e_phys, e_nv, e_lat);
        run_txn("post-rst1", 32'h2000_1000, 2, 0, 2'd3, e_req, e_phys, e_nv, e_lat, 0, 0);
        run_txn("post-rst2", 32'h2000_1000, 2, 0, 2'd3, e_req, e_phys, e_nv, e_lat, 0, 0);
        sbr_req_i = 1'b1; sbr_addr_i = 32'h0300_0010;
        check_blocked("post-rst3", 4);
        sbr_req_i = 1'b0;
        send_rsp("post-rst drain1");
        send_rsp("post-rst drain2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
